char_stream_normalizer: RTL and testbench
=========================================

// Module: char_stream_normalizer
// PURPOSE
//  Front-end stage feeding the begin/end block checker. Accepts a raw ASCII byte stream
//  over a valid/ready handshake and lower-cases letters. Maps TAB/LF/CR to space, collapses
//  whitespace runs to one space, drops non-printables and terminates each text with one
//  space tagged last. Buffers output in a DEPTH-entry FIFO with a word counter.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of two, >=4
//  AW     3   log2(DEPTH); pointer width
//  CW     16  word_count width
// PORTS
//  clk         in   1      clock; all state changes on posedge
//  reset       in   1      asynchronous, active-high
//  in_data     in   8      raw ASCII byte
//  in_valid    in   1      in_data valid
//  in_last     in   1      beat is final byte of current text
//  in_ready    out  1      stage can accept a beat this cycle
//  out_data    out  8      normalized char (FIFO head)
//  out_last    out  1      head is the terminating space of a text
//  out_valid   out  1      FIFO not empty
//  out_ready   in   1      consumer takes head this cycle
//  word_count  out  CW     words emitted since reset, saturating
// BEHAVIOUR
//  - Reset (async): FIFO empty, state RUN, pend_ws=0, seen_word=0, word_count=0,
//    out_valid=0, in_ready=0 while reset high. out_data/out_last are don't-care while empty.
//  - Accept = in_valid & in_ready. in_ready = (state==RUN) & !full, with no path from out_ready.
//  - Class of in_data: WS = {0x20,0x09,0x0A,0x0D}; PR = 0x21..0x7E; everything else DROP.
//    For PR, 'A'..'Z' (0x41..0x5A) gets +0x20; all other PR pass unchanged.
//  - FIFO entry = {last,char}. Push rate is at most 1 per cycle. Pop = out_valid & out_ready.
//    Push and pop in the same cycle leave count unchanged. Pointers wrap mod DEPTH.
//  - FSM states: RUN, HOLD, TERM. Accepted beat in RUN:
//    DROP            : no push.
//    WS              : no push; pend_ws<=seen_word (whitespace is deferred).
//    PR, pend_ws=0   : push {0,lc}; seen_word<=1.
//    PR, pend_ws=1   : push {0,0x20}; hold_char<=lc; hold_last<=in_last; pend_ws<=0; ->HOLD.
//    If in_last and the state is not HOLD: ->TERM after this beat's action.
//  - HOLD: when !full push {0,hold_char}; go to TERM if hold_last, else RUN.
//  - TERM: when !full push {1,0x20}; pend_ws<=0; seen_word<=0; ->RUN. Every in_last yields
//    exactly one trailing {1,0x20}, including whitespace-only and empty texts.
//  - Leading whitespace is discarded (seen_word=0). Trailing whitespace before in_last is
//    absorbed into the terminating space.
//  - word_count: +1 on each push of a PR char that starts a word. That is a PR push in RUN
//    with seen_word=0, or the HOLD push. Holds at 2^CW-1.
//  - Latency: a PR accepted into an empty FIFO appears on out_* the next cycle. The deferred
//    space costs one in_ready-low cycle (HOLD). in_last costs one extra cycle (TERM).
//  - Full: HOLD/TERM wait without loss. A pop while full frees a slot only from the next cycle.
//  - Reset mid-operation aborts all content. No partial text survives.
// TESTING
//  1. "  Begin\tEND\n", last on '\n', out_ready=1 -> "begin end " (last on final 0x20);
//     word_count=2.
//  2. "ab  \r\n cd", last on 'd' -> "ab cd "; in_ready low exactly 1 cycle after 'c'
//     (HOLD) and 1 after TERM entry.
//  3. out_ready=0, offer 10 PR bytes, DEPTH=8 -> 8 accepted then in_ready=0. After
//     out_ready=1, output is the same 8 in order and the rest are accepted.
//  4. "a",0x00,0x7F,0x80,"b", last on 'b' -> "ab " with no space between a and b;
//     word_count +1.
//  5. Whitespace-only "   " with last -> single {1,0x20}; word_count unchanged.
//  6. Assert reset with 5 entries queued and state=HOLD -> out_valid=0 immediately;
//     word_count=0; state RUN; first beat after release is accepted normally.

Source files
------------

// File: rtl/char_stream_normalizer.sv
// Character stream normalizer: lower-cases letters, collapses whitespace runs,
// drops non-printables and closes every text with one space tagged last.
// Output is buffered in a small FIFO; word_count tallies words started.
module char_stream_normalizer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] word_count
);

    typedef enum logic [1:0] {RUN, HOLD, TERM} state_t;

    state_t        state, state_nxt;
    logic          pend_ws, pend_nxt;
    logic          seen_word, seen_nxt;
    logic [7:0]    hold_char;
    logic          hold_last;
    logic          hold_ld;
    logic          wc_inc;
    logic          push;
    logic [8:0]    push_data;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, accept, pop;
    logic          is_ws, is_pr;
    logic [7:0]    lc;

    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = (state == RUN) && !full && !reset;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr][7:0];
    assign out_last  = mem[rd_ptr][8];

    assign is_ws = (in_data == 8'h20) || (in_data == 8'h09) ||
                   (in_data == 8'h0A) || (in_data == 8'h0D);
    assign is_pr = (in_data >= 8'h21) && (in_data <= 8'h7E);
    assign lc    = ((in_data >= 8'h41) && (in_data <= 8'h5A)) ? in_data + 8'h20 : in_data;

    // Next-state, push selection and control-register updates.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = 9'h000;
        pend_nxt  = pend_ws;
        seen_nxt  = seen_word;
        hold_ld   = 1'b0;
        wc_inc    = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (in_last) state_nxt = TERM;
                    if (is_pr) begin
                        if (pend_ws) begin
                            // Emit the deferred space now, the letter next cycle.
                            push      = 1'b1;
                            push_data = {1'b0, 8'h20};
                            hold_ld   = 1'b1;
                            pend_nxt  = 1'b0;
                            state_nxt = HOLD;
                        end else begin
                            push      = 1'b1;
                            push_data = {1'b0, lc};
                            seen_nxt  = 1'b1;
                            wc_inc    = !seen_word;
                        end
                    end else if (is_ws) begin
                        // Leading whitespace never arms a pending space.
                        pend_nxt = seen_word;
                    end
                end
            end
            HOLD: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = {1'b0, hold_char};
                    wc_inc    = 1'b1;
                    state_nxt = hold_last ? TERM : RUN;
                end
            end
            TERM: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = {1'b1, 8'h20};
                    pend_nxt  = 1'b0;
                    seen_nxt  = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Whitespace/word tracking, held character and saturating word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_ws    <= 1'b0;
            seen_word  <= 1'b0;
            hold_char  <= 8'h00;
            hold_last  <= 1'b0;
            word_count <= '0;
        end else begin
            pend_ws   <= pend_nxt;
            seen_word <= seen_nxt;
            if (hold_ld) begin
                hold_char <= lc;
                hold_last <= in_last;
            end
            if (wc_inc && (word_count != {CW{1'b1}}))
                word_count <= word_count + CW'(1);
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_char_stream_normalizer.sv
// Bench for char_stream_normalizer: directed texts, expected output queued
// up front, a negedge monitor pops and compares every transferred beat.
module tb_char_stream_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;
    int low_cnt  = 0;
    logic [8:0] sb[$];

    char_stream_normalizer #(.DEPTH(8), .AW(3), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Monitor: compare every beat the consumer takes against the queue head.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out got=%h expected=none", {out_last, out_data});
            end else begin
                e = sb.pop_front();
                if ({out_last, out_data} !== e) begin
                    failures++;
                    $display("FAIL out_beat got=%h expected=%h", {out_last, out_data}, e);
                end
            end
        end
    end

    // Cycles where the stage refuses input (outside reset).
    always @(negedge clk) if (!reset && !in_ready) low_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_text(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back({1'b0, s[i]});
        sb.push_back({1'b1, 8'h20});
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int waits);
        in_data = d; in_last = l; in_valid = 1'b1; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin waits++; @(negedge clk); end
        if (waits >= 200) chk("send_timeout", 32'(waits), 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        int w;
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_on_end && (i == s.len() - 1), w);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain_left", 32'(sb.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("empty_after_drain", {31'd0, out_valid}, 0);
    endtask

    initial begin
        int w, lo0, zw;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_word_count", 32'(word_count), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // 1: case folding, tab and trailing newline.
        exp_text("begin end");
        send_str("  Begin\tEND\n", 1'b1);
        drain();
        chk("t1_word_count", 32'(word_count), 2);

        // 2: whitespace run collapsed; HOLD and TERM each cost one cycle.
        exp_text("ab cd");
        lo0 = low_cnt;
        send_str("ab  \x0d\n c", 1'b0);
        send("d", 1'b1, w);
        chk("t2_hold_wait", 32'(w), 1);
        drain();
        chk("t2_low_cycles", 32'(low_cnt - lo0), 2);
        chk("t2_word_count", 32'(word_count), 4);

        // 3: back-pressure fills the FIFO at exactly DEPTH entries.
        out_ready = 1'b0;
        exp_text("abcdefghij");
        zw = 0;
        for (int i = 0; i < 8; i++) begin send(8'h61 + 8'(i), 1'b0, w); zw += w; end
        chk("t3_first8_no_wait", 32'(zw), 0);
        in_data = "i"; in_valid = 1'b1;
        repeat (3) begin @(negedge clk); chk("t3_full_in_ready", {31'd0, in_ready}, 0); end
        out_ready = 1'b1;
        send("i", 1'b0, w);
        send("j", 1'b1, w);
        drain();
        chk("t3_word_count", 32'(word_count), 5);

        // 4: non-printables dropped without creating a word break.
        exp_text("ab");
        send("a", 1'b0, w); send(8'h00, 1'b0, w); send(8'h7F, 1'b0, w);
        send(8'h80, 1'b0, w); send("b", 1'b1, w);
        drain();
        chk("t4_word_count", 32'(word_count), 6);

        // 5: whitespace-only text yields only the terminator.
        exp_text("");
        send_str("   ", 1'b1);
        drain();
        chk("t5_word_count", 32'(word_count), 6);

        // 6: reset while HOLD with five entries queued.
        out_ready = 1'b0;
        send_str("abcd e", 1'b0);
        chk("t6_pre_valid", {31'd0, out_valid}, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", {31'd0, out_valid}, 0);
        chk("t6_rst_word_count", 32'(word_count), 0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 0);
        sb.delete();
        @(negedge clk); reset = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_run_in_ready", {31'd0, in_ready}, 1);
        exp_text("q");
        send("Q", 1'b1, w);
        chk("t6_first_beat_wait", 32'(w), 0);
        drain();
        chk("t6_word_count", 32'(word_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
